tcp_vlg_tx_seg: RTL and testbench

Segment payload fetcher; sits directly downstream of the TCP transmit buffer. On request from the TCP transmit controller, it reads `len` bytes starting at the buffer location that corresponds to a given sequence number. It emits them as a byte stream with start-of-frame, end-of-frame and backpressure to the TCP header/packet assembler. In parallel it computes the 16-bit one's-complement payload sum for the TCP checksum.

---
 rtl/tcp_vlg_tx_seg.sv | 156 +++++++++++++++
 tb/tb_tcp_vlg_tx_seg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_tx_seg.sv
// Segment payload fetcher: reads len bytes from the TX buffer,
// streams them with sof/eof/backpressure and sums the payload.
module tcp_vlg_tx_seg #(
  parameter int D = 16,
  parameter int L = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [31:0]  seq_start,
  input  logic [L-1:0] len,
  output logic         busy,
  output logic [D-1:0] buf_addr,
  input  logic [7:0]   buf_data,
  output logic [7:0]   strm_dat,
  output logic         strm_val,
  output logic         strm_sof,
  output logic         strm_eof,
  input  logic         strm_rdy,
  output logic [15:0]  pld_sum,
  output logic         done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] FOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]   state;
  logic [D-1:0] addr_q;
  logic [L-1:0] len_q;
  logic [L-1:0] iss_rem;
  logic [L-1:0] arr_rem;
  logic         rd_pend;
  logic         out_val;
  logic         sk_val;
  logic         lo;
  logic [9:0]   out_q;
  logic [9:0]   sk_q;
  logic [9:0]   in_w;
  logic [31:0]  acc;
  logic [31:0]  addend;
  logic [15:0]  sum_q;
  logic [16:0]  f1;
  logic [15:0]  f2;
  logic [1:0]   occ;
  logic         xfer;
  logic         take;
  logic         issue;
  logic         unused_seq;

  assign unused_seq = ^seq_start[31:D];

  assign xfer = out_val & strm_rdy;
  assign take = ~out_val | xfer;

  // Bytes held or in flight after this edge; a new read needs a free slot.
  assign occ = {1'b0, out_val} + {1'b0, sk_val}
             + {1'b0, rd_pend} - {1'b0, xfer};
  assign issue = (state == FETCH) && (occ < 2'd2);

  assign in_w = {arr_rem == len_q, arr_rem == L'(1), buf_data};

  assign addend = lo ? {24'd0, out_q[7:0]}
                     : {16'd0, out_q[7:0], 8'd0};

  assign f1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
  assign f2 = f1[15:0] + {15'd0, f1[16]};

  assign busy     = (state == FETCH) || (state == DRAIN)
                 || (state == FOLD);
  assign done     = (state == DONE);
  assign buf_addr = addr_q;
  assign strm_val = out_val;
  assign strm_sof = out_q[9];
  assign strm_eof = out_q[8];
  assign strm_dat = out_q[7:0];
  assign pld_sum  = sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      out_val <= 1'b0;
      sk_val  <= 1'b0;
      out_q   <= '0;
      sk_q    <= '0;
    end else begin
      rd_pend <= issue;
      if (take) begin
        if (sk_val) begin
          out_q   <= sk_q;
          out_val <= 1'b1;
          sk_val  <= rd_pend;
          if (rd_pend) sk_q <= in_w;
        end else begin
          out_val <= rd_pend;
          if (rd_pend) out_q <= in_w;
        end
      end else if (rd_pend) begin
        sk_q   <= in_w;
        sk_val <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      iss_rem <= '0;
      arr_rem <= '0;
      acc     <= '0;
      lo      <= 1'b0;
      sum_q   <= '0;
    end else begin
      if (xfer) begin
        acc <= acc + addend;
        lo  <= ~lo;
      end
      if (rd_pend) arr_rem <= arr_rem - 1'b1;
      unique case (state)
        IDLE: begin
          if (req) begin
            len_q   <= len;
            iss_rem <= len;
            arr_rem <= len;
            addr_q  <= seq_start[D-1:0];
            acc     <= '0;
            lo      <= 1'b0;
            sum_q   <= '0;
            state   <= (len == '0) ? FOLD : FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            addr_q  <= addr_q + 1'b1;
            iss_rem <= iss_rem - 1'b1;
            if (iss_rem == L'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && out_q[8]) state <= FOLD;
        end
        FOLD: begin
          sum_q <= f2;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_vlg_tx_seg.sv
// Directed bench for tcp_vlg_tx_seg with a 16-byte buffer model.
// Expected bytes, flags, timing and sums are hand-derived.
module tb_tcp_vlg_tx_seg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] seq_start = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic [3:0]  buf_addr;
  logic [7:0]  buf_data;
  logic [7:0]  strm_dat;
  logic        strm_val;
  logic        strm_sof;
  logic        strm_eof;
  logic        strm_rdy = 1'b0;
  logic [15:0] pld_sum;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always_ff @(posedge clk) buf_data <= mem[buf_addr];

  tcp_vlg_tx_seg #(.D(4), .L(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .seq_start(seq_start),
    .len(len),
    .busy(busy),
    .buf_addr(buf_addr),
    .buf_data(buf_data),
    .strm_dat(strm_dat),
    .strm_val(strm_val),
    .strm_sof(strm_sof),
    .strm_eof(strm_eof),
    .strm_rdy(strm_rdy),
    .pld_sum(pld_sum),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: rdy=1, 1: random runs of 1..12, 2: toggle each cycle
  task automatic seg(input string tag, input logic [31:0] s,
                     input int n, input int mode,
                     input logic [15:0] exp_sum, input bit extra);
    int idx = 0;
    int first = -1;
    int dcyc = -1;
    int runl = 0;
    bit lvl = 1'b1;
    bit hold = 1'b0;
    logic [9:0] prev = '0;
    logic [3:0] a;
    seq_start = s;
    len = n[15:0];
    req = 1'b1;
    cyc();
    req = 1'b0;
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      case (mode)
        1: begin
          if (runl == 0) begin
            lvl = 1'($urandom_range(0, 1));
            runl = $urandom_range(1, 12);
          end
          strm_rdy = lvl;
          runl--;
        end
        2: strm_rdy = c[0];
        default: strm_rdy = 1'b1;
      endcase
      if (extra && c == 3) begin
        seq_start = 32'h5;
        len = 16'd5;
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      if (c == 1) chk({tag, " busy"}, 32'(busy), 32'd1);
      if (mode == 0 && c <= n)
        chk({tag, " addr"}, 32'(buf_addr), 32'(4'(s[3:0] + c - 1)));
      if (hold)
        chk({tag, " hold"},
            32'({strm_val, strm_sof, strm_eof, strm_dat}),
            32'({1'b1, prev}));
      hold = strm_val && !strm_rdy;
      prev = {strm_sof, strm_eof, strm_dat};
      if (strm_val && first < 0) first = c;
      if (strm_val && strm_rdy) begin
        a = 4'(s[3:0] + 4'(idx));
        chk({tag, " byte"}, 32'({strm_sof, strm_eof, strm_dat}),
            32'({idx == 0, idx == n - 1, mem[a]}));
        idx++;
      end
      if (done) begin
        dcyc = c;
        chk({tag, " sum"}, 32'(pld_sum), 32'(exp_sum));
        chk({tag, " count"}, idx, n);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      end
      cyc();
    end
    chk({tag, " done_seen"}, 32'(dcyc >= 0), 32'd1);
    if (mode == 0) begin
      chk({tag, " done_cyc"}, dcyc, (n == 0) ? 2 : n + 4);
      if (n > 0) chk({tag, " first_val"}, first, 3);
    end
    req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'h03;
    mem[3] = 8'h04;
    mem[5] = 8'hFF;
    mem[6] = 8'hFF;
    mem[7] = 8'h01;

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst val", 32'(strm_val), 32'd0);
    chk("rst sum", 32'(pld_sum), 32'd0);
    chk("rst addr", 32'(buf_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    seg("basic", 32'h10, 4, 0, 16'h0406, 1'b0);
    seg("odd", 32'h5, 3, 0, 16'h0100, 1'b0);
    seg("wrap", 32'h1234_567E, 4, 0, 16'h4F51, 1'b0);
    seg("len1", 32'h2, 1, 0, 16'h0300, 1'b0);
    seg("bp_rdy1", 32'h0, 64, 0, 16'hD4E1, 1'b0);
    seg("bp_rand", 32'h0, 64, 1, 16'hD4E1, 1'b0);
    seg("bp_tog", 32'h0, 64, 2, 16'hD4E1, 1'b0);
    seg("zero", 32'h7, 0, 0, 16'h0000, 1'b0);
    seg("ignore", 32'h10, 4, 0, 16'h0406, 1'b1);

    seq_start = 32'h0;
    len = 16'd20;
    strm_rdy = 1'b1;
    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (7) cyc();
    rst = 1'b0;
    #1;
    chk("abort val", 32'(strm_val), 32'd0);
    chk("abort flags", 32'({strm_sof, strm_eof}), 32'd0);
    chk("abort dat", 32'(strm_dat), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort addr", 32'(buf_addr), 32'd0);
    chk("abort sum", 32'(pld_sum), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort quiet", 32'({done, strm_val}), 32'd0);
    end
    rst = 1'b1;
    cyc();
    seg("after_rst", 32'h3, 2, 0, 16'h0444, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
